// File: rtl/alu_result_trace.sv
// Capture stage for Simple_Single_CPU: samples ALU_result into a stamped FWFT FIFO with a valid/ready drain.
// Optional TRACE_DEDUP_EN: suppress pushes whose value equals the last value offered to the FIFO.
module alu_result_trace #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int STAMP_W   = 16,
   parameter int END_COUNT = 25
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic [DATA_W-1:0]        alu_result_i,
   output logic                     rd_valid_o,
   input  logic                     rd_ready_i,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic [STAMP_W-1:0]       rd_stamp_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     done_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = STAMP_W + DATA_W;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam logic [STAMP_W-1:0] END_STAMP  = STAMP_W'(END_COUNT);
   localparam logic [AW:0]        FULL_LEVEL = (AW+1)'(DEPTH);

   logic [1:0]         state_reg, state_next;
   logic [STAMP_W-1:0] cycle_cnt_reg, cycle_cnt_next;
   logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]        level_reg, level_next;
   logic               overflow_reg;
   logic [EW-1:0]      mem [DEPTH];

   logic               capture_fire;
   logic               push_req;
   logic               push_ok;
   logic               pop;
   logic               full;
   logic               empty;
   logic [STAMP_W-1:0] stamp_now;
   logic [EW-1:0]      head;

   assign capture_fire = enable_i && (state_reg != ST_DONE);
   assign stamp_now    = cycle_cnt_reg + STAMP_W'(1);
   assign full         = (level_reg == FULL_LEVEL);
   assign empty        = (level_reg == '0);
   assign pop          = !empty && rd_ready_i;
   // A simultaneous pop frees the slot, so a full FIFO can still accept.
   assign push_ok      = push_req && (!full || pop);

`ifdef TRACE_DEDUP_EN
   // No valid flag on the compare register: a leading 0 sample is treated as a repeat.
   logic [DATA_W-1:0] last_reg;
   assign push_req = capture_fire && (alu_result_i != last_reg);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_reg <= '0;
      end else if (push_req) begin
         last_reg <= alu_result_i;
      end
   end
`else
   assign push_req = capture_fire;
`endif

   always_comb begin
      state_next     = state_reg;
      cycle_cnt_next = cycle_cnt_reg;
      if (capture_fire) begin
         cycle_cnt_next = stamp_now;
         state_next     = (stamp_now == END_STAMP) ? ST_DONE : ST_CAPTURE;
      end
   end

   always_comb begin
      level_next = level_reg;
      case ({push_ok, pop})
         2'b10:   level_next = level_reg + (AW+1)'(1);
         2'b01:   level_next = level_reg - (AW+1)'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg     <= ST_IDLE;
         cycle_cnt_reg <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cycle_cnt_reg <= cycle_cnt_next;
         level_reg     <= level_next;
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (push_req && full && !pop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Storage carries no reset; stale contents are masked by the empty flag.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= {stamp_now, alu_result_i};
      end
   end

   assign head       = mem[rd_ptr_reg];
   assign rd_valid_o = !empty;
   assign rd_data_o  = empty ? '0 : head[DATA_W-1:0];
   assign rd_stamp_o = empty ? '0 : head[EW-1:DATA_W];
   assign level_o    = level_reg;
   assign done_o     = (state_reg == ST_DONE);
   assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_alu_result_trace.sv
// Self-checking bench for alu_result_trace against a queue-based reference model.
// Build with +define+TRACE_DEDUP_EN on both files to exercise the dedup variant.
module tb_alu_result_trace;

   localparam int DATA_W    = 32;
   localparam int DEPTH     = 16;
   localparam int STAMP_W   = 16;
   localparam int END_COUNT = 25;
   localparam int LW        = $clog2(DEPTH) + 1;
   localparam int VW        = 1 + DATA_W + STAMP_W + LW + 1 + 1;

   logic              clk;
   logic              rst_i;
   logic              enable_i;
   logic [DATA_W-1:0] alu_result_i;
   logic              rd_valid_o;
   logic              rd_ready_i;
   logic [DATA_W-1:0] rd_data_o;
   logic [STAMP_W-1:0] rd_stamp_o;
   logic [LW-1:0]     level_o;
   logic              done_o;
   logic              overflow_o;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int                q_stamp[$];
   logic [DATA_W-1:0] q_data[$];
   int                m_cap;
   bit                m_done;
   bit                m_ovf;
   logic [DATA_W-1:0] m_last;

   alu_result_trace #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W), .END_COUNT(END_COUNT)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .alu_result_i(alu_result_i),
      .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
      .rd_stamp_o(rd_stamp_o), .level_o(level_o), .done_o(done_o), .overflow_o(overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VW-1:0] got_vec();
      return {rd_valid_o, rd_data_o, rd_stamp_o, level_o, done_o, overflow_o};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [DATA_W-1:0]  d;
      logic [STAMP_W-1:0] s;
      d = '0;
      s = '0;
      if (q_stamp.size() > 0) begin
         d = q_data[0];
         s = STAMP_W'(q_stamp[0]);
      end
      return {q_stamp.size() > 0, d, s, LW'(q_stamp.size()), m_done, m_ovf};
   endfunction

   task automatic model_clear();
      q_stamp.delete();
      q_data.delete();
      m_cap  = 0;
      m_done = 0;
      m_ovf  = 0;
      m_last = '0;
   endtask

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      int sz;
      bit pop;
      bit push;
      sz   = q_stamp.size();
      pop  = (sz > 0) && rd_ready_i;
      push = 0;
      if (enable_i && !m_done) begin
         m_cap++;
`ifdef TRACE_DEDUP_EN
         if (alu_result_i != m_last) begin
            push   = 1;
            m_last = alu_result_i;
         end
`else
         push = 1;
`endif
         if (m_cap == END_COUNT) m_done = 1;
      end
      if (pop) begin
         $display("pop   stamp=%0d data=%0d", q_stamp[0], q_data[0]);
         void'(q_stamp.pop_front());
         void'(q_data.pop_front());
      end
      if (push) begin
         if (sz == DEPTH && !pop) begin
            m_ovf = 1;
            $display("drop  stamp=%0d data=%0d", m_cap, alu_result_i);
         end else begin
            q_stamp.push_back(m_cap);
            q_data.push_back(alu_result_i);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i        = 1'b0;
      enable_i     = 1'b0;
      rd_ready_i   = 1'b0;
      alu_result_i = '0;
      model_clear();
      @(posedge clk);
      #1;
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_i        = 1'b0;
      enable_i     = 1'b0;
      rd_ready_i   = 1'b0;
      alu_result_i = '0;
      model_clear();
      #2;
      checks++;
      if (got_vec() !== '0) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", got_vec(), {VW{1'b0}});
      end
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL reset_idle got=%h exp=%h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_stream();
      int pops;
      pops = 0;
      do_reset();
      enable_i   = 1'b1;
      rd_ready_i = 1'b1;
      for (int i = 0; i < END_COUNT + 4; i++) begin
         alu_result_i = DATA_W'((m_cap + 1) * 3);
         if (rd_valid_o) begin
            pops++;
            checks++;
            if (rd_stamp_o !== STAMP_W'(pops) || rd_data_o !== DATA_W'(pops * 3)) begin
               failures++;
               $display("FAIL stream_pop got=(%0d,%0d) exp=(%0d,%0d)",
                        rd_stamp_o, rd_data_o, pops, pops * 3);
            end
         end
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL stream_cycle%0d got=%h exp=%h", i, got_vec(), exp_vec());
         end
      end
      checks++;
      if (pops != END_COUNT || done_o !== 1'b1 || overflow_o !== 1'b0) begin
         failures++;
         $display("FAIL stream_end got pops=%0d done=%b ovf=%b exp pops=%0d done=1 ovf=0",
                  pops, done_o, overflow_o, END_COUNT);
      end
   endtask

   task automatic test_overflow();
      int pops;
      pops = 0;
      do_reset();
      enable_i   = 1'b1;
      rd_ready_i = 1'b0;
      for (int i = 0; i < END_COUNT; i++) begin
         alu_result_i = $urandom;
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL ovf_fill%0d got=%h exp=%h", i, got_vec(), exp_vec());
         end
      end
      checks++;
      if (level_o !== LW'(DEPTH) || overflow_o !== 1'b1 || done_o !== 1'b1) begin
         failures++;
         $display("FAIL ovf_full got level=%0d ovf=%b done=%b exp level=%0d ovf=1 done=1",
                  level_o, overflow_o, done_o, DEPTH);
      end
      rd_ready_i = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (rd_valid_o) begin
            pops++;
            checks++;
            if (rd_stamp_o !== STAMP_W'(pops)) begin
               failures++;
               $display("FAIL ovf_drain got stamp=%0d exp=%0d", rd_stamp_o, pops);
            end
         end
         tick();
      end
      checks++;
      if (pops != DEPTH || rd_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
         failures++;
         $display("FAIL ovf_drained got pops=%0d valid=%b ovf=%b exp pops=%0d valid=0 ovf=1",
                  pops, rd_valid_o, overflow_o, DEPTH);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      enable_i   = 1'b1;
      rd_ready_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         alu_result_i = $urandom;
         tick();
      end
      checks++;
      if (level_o !== LW'(DEPTH) || overflow_o !== 1'b0) begin
         failures++;
         $display("FAIL fullpop_fill got level=%0d ovf=%b exp level=%0d ovf=0",
                  level_o, overflow_o, DEPTH);
      end
      rd_ready_i   = 1'b1;
      alu_result_i = $urandom;
      tick();
      checks++;
      if (level_o !== LW'(DEPTH) || overflow_o !== 1'b0 || rd_stamp_o !== 16'd2) begin
         failures++;
         $display("FAIL fullpop_same got level=%0d ovf=%b stamp=%0d exp level=%0d ovf=0 stamp=2",
                  level_o, overflow_o, rd_stamp_o, DEPTH);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL fullpop_model got=%h exp=%h", got_vec(), exp_vec());
      end
      rd_ready_i   = 1'b0;
      alu_result_i = $urandom;
      tick();
      checks++;
      if (overflow_o !== 1'b1 || got_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL fullpop_drop got=%h exp=%h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_enable_gap();
      int next_stamp;
      next_stamp = 1;
      do_reset();
      rd_ready_i = 1'b1;
      for (int i = 0; i < END_COUNT + 5; i++) begin
         enable_i     = !(i >= 4 && i <= 6);
         alu_result_i = $urandom;
         if (rd_valid_o) begin
            checks++;
            if (rd_stamp_o !== STAMP_W'(next_stamp)) begin
               failures++;
               $display("FAIL gap_stamp got=%0d exp=%0d", rd_stamp_o, next_stamp);
            end
            next_stamp++;
         end
         tick();
         checks++;
         if (done_o !== (i >= END_COUNT + 2) || got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL gap_cycle%0d got=%h exp=%h done_exp=%b",
                     i, got_vec(), exp_vec(), i >= END_COUNT + 2);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      enable_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rd_ready_i   = (i >= 1 && i <= 4);
         alu_result_i = DATA_W'(i + 100);
         tick();
      end
      checks++;
      if (level_o !== LW'(6) || got_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL arst_pre got=%h exp=%h level_exp=6", got_vec(), exp_vec());
      end
      #3;
      rst_i = 1'b0;
      model_clear();
      #1;
      checks++;
      if (got_vec() !== '0) begin
         failures++;
         $display("FAIL arst_immediate got=%h exp=%h", got_vec(), {VW{1'b0}});
      end
      @(posedge clk);
      #1;
      rst_i        = 1'b1;
      rd_ready_i   = 1'b0;
      alu_result_i = 32'h55;
      tick();
      checks++;
      if (rd_valid_o !== 1'b1 || rd_stamp_o !== 16'd1 || rd_data_o !== 32'h55) begin
         failures++;
         $display("FAIL arst_restart got valid=%b stamp=%0d data=%0h exp valid=1 stamp=1 data=55",
                  rd_valid_o, rd_stamp_o, rd_data_o);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 79) == 0) do_reset();
         enable_i     = ($urandom_range(0, 3) != 0);
         rd_ready_i   = $urandom_range(0, 1);
`ifdef TRACE_DEDUP_EN
         alu_result_i = DATA_W'($urandom_range(0, 3));
`else
         alu_result_i = $urandom;
`endif
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random_cycle%0d got=%h exp=%h", i, got_vec(), exp_vec());
         end
      end
   endtask

`ifdef TRACE_DEDUP_EN
   task automatic test_dedup();
      int exp_s[3];
      int exp_d[3];
      exp_s = '{1, 4, 6};
      exp_d = '{7, 9, 0};
      do_reset();
      enable_i   = 1'b1;
      rd_ready_i = 1'b0;
      for (int i = 0; i < END_COUNT; i++) begin
         alu_result_i = (i < 3) ? 32'd7 : (i < 5) ? 32'd9 : 32'd0;
         tick();
      end
      checks++;
      if (level_o !== LW'(3) || done_o !== 1'b1 || overflow_o !== 1'b0) begin
         failures++;
         $display("FAIL dedup_level got level=%0d done=%b ovf=%b exp level=3 done=1 ovf=0",
                  level_o, done_o, overflow_o);
      end
      rd_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rd_valid_o !== 1'b1 || rd_stamp_o !== STAMP_W'(exp_s[k]) ||
             rd_data_o !== DATA_W'(exp_d[k])) begin
            failures++;
            $display("FAIL dedup_entry%0d got=(%0d,%0d) exp=(%0d,%0d)",
                     k, rd_stamp_o, rd_data_o, exp_s[k], exp_d[k]);
         end
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_overflow();
      test_full_pop();
      test_enable_gap();
      test_async_reset();
`ifdef TRACE_DEDUP_EN
      test_dedup();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
